sx_bus_cycle_ctrl: RTL



---
 rtl/sx_bus_pkg.sv | 24 ++
 rtl/sx_bus_cycle_ctrl_if.sv | 36 +++
 rtl/sx_cycle_decode.sv | 29 ++
 rtl/sx_bus_cycle_ctrl.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/sx_bus_pkg.sv
// Shared definitions for the Am386SX bus-cycle controller: cycle types,
// FSM states and the CPU reset vector.
package sx_bus_pkg;

  typedef enum logic [2:0] {
    CYC_INTA,
    CYC_IO_RD,
    CYC_IO_WR,
    CYC_CODE,
    CYC_SPECIAL,
    CYC_MEM_RD,
    CYC_MEM_WR
  } cyc_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RDY
  } state_t;

  localparam logic [23:0] RESET_VECTOR = 24'hFFFFF0;

endpackage

// File: rtl/sx_bus_cycle_ctrl_if.sv
// CPU pin-side and back-end signals of the bus-cycle controller.
// slave = controller view, master = CPU/back-end view.
interface sx_bus_cycle_ctrl_if;
  logic        ads_n;
  logic        mio;
  logic        dc;
  logic        wr;
  logic [1:0]  be_n;
  logic [22:0] addr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        data_oe;
  logic        ready_n;
  logic        req;
  logic [23:0] req_addr;
  logic        req_we;
  logic        req_io;
  logic [1:0]  req_be;
  logic [15:0] req_wdata;
  logic        ack;
  logic [15:0] ack_rdata;
  logic        special_cyc;
  logic        bus_err;

  modport slave (
    input  ads_n, mio, dc, wr, be_n, addr, data_in, ack, ack_rdata,
    output data_out, data_oe, ready_n, req, req_addr, req_we, req_io,
           req_be, req_wdata, special_cyc, bus_err
  );

  modport master (
    output ads_n, mio, dc, wr, be_n, addr, data_in, ack, ack_rdata,
    input  data_out, data_oe, ready_n, req, req_addr, req_we, req_io,
           req_be, req_wdata, special_cyc, bus_err
  );
endinterface

// File: rtl/sx_cycle_decode.sv
// Combinational decode of the 386SX cycle-definition pins {M/IO#, D/C#, W/R#}.
module sx_cycle_decode
  import sx_bus_pkg::*;
(
  input  logic mio,
  input  logic dc,
  input  logic wr,
  output cyc_t cyc,
  output logic needs_req,
  output logic is_write
);

  always_comb begin
    cyc = CYC_SPECIAL;
    case ({mio, dc, wr})
      3'b000:  cyc = CYC_INTA;
      3'b001:  cyc = CYC_SPECIAL;
      3'b010:  cyc = CYC_IO_RD;
      3'b011:  cyc = CYC_IO_WR;
      3'b100:  cyc = CYC_CODE;
      3'b101:  cyc = CYC_SPECIAL;
      3'b110:  cyc = CYC_MEM_RD;
      default: cyc = CYC_MEM_WR;
    endcase
    needs_req = (cyc != CYC_INTA) && (cyc != CYC_SPECIAL);
    is_write  = wr;
  end

endmodule

// File: rtl/sx_bus_cycle_ctrl.sv
// Translates each Am386SX bus cycle into one back-end req/ack transaction
// and drives READY#/read data. Optional back-end timeout: define TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for a falling ADS#
// REQ   | first cycle captures write data and raises req; then wait for ack
// WAIT  | hold off READY# until WAIT_STATES cycles since address latch
// RDY   | READY# low for two clk (one CPU T2 phase)
module sx_bus_cycle_ctrl
  import sx_bus_pkg::*;
#(
  parameter int          WAIT_STATES = 2,
  parameter int          TIMEOUT     = 64,
  parameter logic [15:0] FLOAT_DATA  = 16'hFFFF
) (
  input  logic                clk,
  input  logic                reset_n,
  sx_bus_cycle_ctrl_if.slave  bus
);

  localparam int CNT_MAX = (TIMEOUT > WAIT_STATES) ? TIMEOUT : WAIT_STATES;
  localparam int CW      = $clog2(CNT_MAX + 1) + 1;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          rdy_phase;
  logic          ads_q;
  logic          drive_rd;

  cyc_t dec_cyc;
  logic dec_needs_req;
  logic dec_is_write;

  sx_cycle_decode u_decode (
    .mio       (bus.mio),
    .dc        (bus.dc),
    .wr        (bus.wr),
    .cyc       (dec_cyc),
    .needs_req (dec_needs_req),
    .is_write  (dec_is_write)
  );

  // Only a fresh ADS# falling edge starts a cycle, so a strobe held low is latched once.
  logic ads_start;
  assign ads_start = !bus.ads_n && ads_q;

`ifndef TIMEOUT_EN
  assign bus.bus_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      cnt             <= '0;
      rdy_phase       <= 1'b0;
      ads_q           <= 1'b1;
      drive_rd        <= 1'b0;
      bus.data_out    <= '0;
      bus.data_oe     <= 1'b0;
      bus.ready_n     <= 1'b1;
      bus.req         <= 1'b0;
      bus.req_addr    <= '0;
      bus.req_we      <= 1'b0;
      bus.req_io      <= 1'b0;
      bus.req_be      <= '0;
      bus.req_wdata   <= '0;
      bus.special_cyc <= 1'b0;
`ifdef TIMEOUT_EN
      bus.bus_err     <= 1'b0;
`endif
    end else begin
      ads_q           <= bus.ads_n;
      bus.special_cyc <= 1'b0;
`ifdef TIMEOUT_EN
      bus.bus_err     <= 1'b0;
`endif
      if ((state == REQ || state == WAIT) && cnt != CW'(CNT_MAX))
        cnt <= cnt + 1'b1;

      case (state)
        IDLE: begin
          if (ads_start) begin
            cnt          <= '0;
            bus.req_addr <= {bus.addr, 1'b0};
            bus.req_be   <= ~bus.be_n;
            bus.req_we   <= dec_is_write && dec_needs_req;
            bus.req_io   <= (dec_cyc == CYC_IO_RD) || (dec_cyc == CYC_IO_WR);
            drive_rd     <= !dec_is_write;
            if (dec_needs_req) begin
              state <= REQ;
            end else begin
              state <= WAIT;
              if (dec_cyc == CYC_INTA) bus.data_out <= FLOAT_DATA;
              else                     bus.special_cyc <= 1'b1;
            end
          end
        end

        REQ: begin
          if (!bus.req) begin
            bus.req <= 1'b1;
            if (bus.req_we) bus.req_wdata <= bus.data_in;
          end else if (bus.ack) begin
            bus.req      <= 1'b0;
            bus.data_out <= bus.ack_rdata;
            state        <= WAIT;
          end
`ifdef TIMEOUT_EN
          else if (cnt == CW'(TIMEOUT - 1)) begin
            bus.req      <= 1'b0;
            bus.bus_err  <= 1'b1;
            bus.data_out <= FLOAT_DATA;
            bus.ready_n  <= 1'b0;
            bus.data_oe  <= drive_rd;
            rdy_phase    <= 1'b0;
            state        <= RDY;
          end
`endif
        end

        WAIT: begin
          if (cnt >= CW'(WAIT_STATES)) begin
            bus.ready_n <= 1'b0;
            bus.data_oe <= drive_rd;
            rdy_phase   <= 1'b0;
            state       <= RDY;
          end
        end

        RDY: begin
          if (!rdy_phase) begin
            rdy_phase <= 1'b1;
          end else begin
            bus.ready_n <= 1'b1;
            bus.data_oe <= 1'b0;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
